// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALUOp codes, datapath mux selects and the opcode class type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_IMM_EXEC  = 4'd10;
    localparam logic [3:0] S_IMM_WB    = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_MEMOP,
        CLS_RTYPE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_IMM,
        CLS_ILLEGAL
    } op_class_e;

    // ALU operation for the immediate group; addi (and anything else) adds.
    function automatic logic [2:0] imm_aluop(input logic [5:0] opc);
        case (opc)
            OP_SLTI: imm_aluop = ALU_SLT;
            OP_ANDI: imm_aluop = ALU_AND;
            OP_ORI:  imm_aluop = ALU_OR;
            default: imm_aluop = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode classifier; optional instruction groups fold into
// CLS_ILLEGAL when disabled.
module ctrl_opcode_class
    import mips_ctrl_pkg::*;
#(
    parameter int EN_IMM  = 1,
    parameter int EN_JUMP = 1
) (
    input  logic [5:0] opcode_i,
    output op_class_e  op_class_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_LW, OP_SW: op_class_o = CLS_MEMOP;
            OP_RTYPE:     op_class_o = CLS_RTYPE;
            OP_BEQ:       op_class_o = CLS_BRANCH;
            OP_J:         if (EN_JUMP != 0) op_class_o = CLS_JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:
                          if (EN_IMM != 0) op_class_o = CLS_IMM;
            default:      op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the shared-ALU multicycle MIPS datapath; memory states
// stall on mem_ready and unsupported opcodes park the FSM in TRAP.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int EN_IMM  = 1,
    parameter int EN_JUMP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ImmZext,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic [3:0]         state,
    output logic               illegal_op
);

    logic [3:0] state_q, state_d;
    logic [5:0] opc_q, opc_d;
    op_class_e  op_class;

    ctrl_opcode_class #(
        .EN_IMM  (EN_IMM),
        .EN_JUMP (EN_JUMP)
    ) u_class (
        .opcode_i   (opcode),
        .op_class_o (op_class)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            opc_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opc_d = opcode;
                case (op_class)
                    CLS_MEMOP:  state_d = S_MEM_ADDR;
                    CLS_RTYPE:  state_d = S_EXECUTE;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    CLS_IMM:    state_d = S_IMM_EXEC;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opc_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    logic       pc_wr, pc_wr_cond, mem_wr, ir_wr, reg_wr;
    logic [2:0] aluop;

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ImmZext    = 1'b0;
        aluop      = ALU_ADD;
        PCSource   = PCSRC_ALU;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ir_wr   = mem_ready;
                pc_wr   = mem_ready;
            end
            S_DECODE:    ALUSrcB = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                reg_wr   = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_wr = 1'b1;
                IorD   = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                aluop   = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_wr = 1'b1;
                RegDst = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                aluop      = ALU_SUB;
                pc_wr_cond = 1'b1;
                PCSource   = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_wr    = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                aluop   = imm_aluop(opc_q);
                ImmZext = (opc_q == OP_ANDI) || (opc_q == OP_ORI);
            end
            S_IMM_WB:    reg_wr = 1'b1;
            S_TRAP:      illegal_op = 1'b1;
            default: ;
        endcase
    end

    // Write enables are masked by rst so a reset mid-instruction never commits.
    assign PCWrite     = pc_wr      & ~rst;
    assign PCWriteCond = pc_wr_cond & ~rst;
    assign MemWrite    = mem_wr     & ~rst;
    assign IRWrite     = ir_wr      & ~rst;
    assign RegWrite    = reg_wr     & ~rst;
    assign ALUOp       = ALUOP_W'(aluop);
    assign state       = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM controller for the multicycle MIPS datapath: one instruction takes 3-5 cycles, and the datapath shares the ALU and memory across those cycles.
- Decodes the 6-bit opcode in DECODE and sequences the datapath control signals each cycle.
- Stalls on a memory-ready handshake so variable-latency memory is supported.
- Instruction set is R-type, lw, sw, beq, plus optional immediate-ALU and jump groups; unsupported opcodes trap.

Parameters:
- ALUOP_W, 3, width of the ALUOp output; must be >= 3, upper bits driven 0.
- EN_IMM, 1, 1 enables addi/andi/ori/slti; 0 makes them illegal.
- EN_JUMP, 1, 1 enables j; 0 makes it illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register; sampled in DECODE only.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU zero is set (beq).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register: 0=rt, 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU input A: 0=PC, 1=A.
- ALUSrcB  out  2  ALU input B: 00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2.
- ImmZext  out  1  zero-extend the immediate instead of sign-extend (andi/ori).
- ALUOp  out  ALUOP_W  0=add, 1=sub, 2=use funct, 3=and, 4=or, 5=slt.
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  high while in TRAP.

Behaviour:
- Opcode map:
  - R=000000, lw=100011, sw=101011, beq=000100.
  - j=000010.
  - addi=001000, slti=001010, andi=001100, ori=001101.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, TRAP=12.
- State register updates on the rising clk edge. rst forces FETCH immediately (asynchronous).
- Outputs decode combinationally from the state register and mem_ready.
- All write enables (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) are gated low while rst=1.
- Every output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Go to DECODE when mem_ready=1, otherwise hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=add (computes the branch target).
  - Next state: lw/sw→MEM_ADDR, R→EXECUTE, beq→BRANCH, j→JUMP (if EN_JUMP), imm group→IMM_EXEC (if EN_IMM), anything else→TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add. lw→MEM_READ, sw→MEM_WRITE. Uses the opcode latched at DECODE.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=funct. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- IMM_EXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp: addi→add, slti→slt, andi→and, ori→or.
  - ImmZext=1 for andi/ori.
  - Go to IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- TRAP: illegal_op=1, all writes 0. Remains in TRAP until rst.
- Opcode latch: a 6-bit register loads opcode in DECODE; later states use the latched value. Reset value is 0.
- Zero-wait latency in cycles: R=4, lw=5, sw=4, beq=3, j=3, imm=4. Each mem_ready=0 cycle in a memory state adds 1.
- Undefined state encodings (13-15) go to TRAP.
- Reset mid-instruction: the next cycle is FETCH and no write is issued during rst.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants;
  - state encodings;
  - ALUOp codes;
  - ALUSrcB and PCSource encodings.
- Sub-module ctrl_opcode_class: combinational decode of opcode to a class (MEMOP, RTYPE, BRANCH, JUMP, IMM, ILLEGAL), honouring EN_IMM and EN_JUMP.
- The FSM and output decode live in the top module.

Test Plan:
- rst pulse, then opcode=000000, mem_ready=1 → states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; 4 cycles total.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ → state 3 held 3 cycles with MemRead=1 and IorD=1, then state 4 with MemtoReg=1; 7 cycles total.
- sw (101011) with FETCH mem_ready delayed 1 cycle → IRWrite=1 only in the ready cycle; MemWrite=1 in state 5; RegWrite never 1.
- beq (000100) then j (000010) → BRANCH: PCWriteCond=1, ALUOp=1, PCSource=01; JUMP: PCWrite=1, PCSource=10; each 3 cycles.
- ori (001101) with EN_IMM=1 → IMM_EXEC ALUOp=4, ImmZext=1. Same opcode with EN_IMM=0 → state 12, illegal_op=1 held until rst.
- rst asserted during MEM_WRITE while mem_ready=1 → MemWrite=0 immediately; state=0 after release.
